// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU control codes, decoder classes, funct codes, forwarding selects
// and the registered EX-stage state shared by the ID/EX pipeline register.
package id_ex_stage_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  typedef enum logic [1:0] {AOP_ADD = 2'b00, AOP_SUB = 2'b01, AOP_RTYPE = 2'b10, AOP_OR = 2'b11} alu_op_e;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, FWD_REG_ALT = 2'b11} fwd_sel_e;
  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        valid;
    logic        illegal;
  } ex_state_t;
  // A bubble still presents ADD so the ALU sees a harmless operation.
  localparam ex_state_t EX_BUBBLE = '{rs: 32'd0, rt: 32'd0, imm: 32'd0, dest: 5'd0, alu_ctrl: ALU_ADD,
                                      alu_src: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                      mem_to_reg: 1'b0, valid: 1'b0, illegal: 1'b0};
  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] r,
                                          input logic [31:0] exmem, input logic [31:0] memwb);
    return sel == FWD_EXMEM ? exmem : sel == FWD_MEMWB ? memwb : r;
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, hazard/forwarding controls and EX-side outputs of the ID/EX register.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;
  logic [31:0] input1;
  logic [31:0] input2;
  logic [3:0]  ALUCtrl;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_valid;
  logic        ex_illegal;
  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rt, id_rd, id_alu_op, id_funct,
           id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           fwd_a_sel, fwd_b_sel, exmem_result, memwb_result,
    input  input1, input2, ALUCtrl, ex_store_data, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_valid, ex_illegal
  );
  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_rt, id_rd, id_alu_op, id_funct,
           id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           fwd_a_sel, fwd_b_sel, exmem_result, memwb_result,
    output input1, input2, ALUCtrl, ex_store_data, ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, ex_valid, ex_illegal
  );
endinterface

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALU control decode from main-decoder class and R-type funct.
module alu_ctrl_dec
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal
);
  logic [3:0] w_rtype;
  logic       w_known;
  always_comb begin
    w_rtype = ALU_ADD;
    w_known = 1'b1;
    case (i_funct)
      FN_ADD:  w_rtype = ALU_ADD;
      FN_SUB:  w_rtype = ALU_SUB;
      FN_AND:  w_rtype = ALU_AND;
      FN_OR:   w_rtype = ALU_OR;
      FN_SLT:  w_rtype = ALU_SLT;
      default: w_known = 1'b0;
    endcase
    o_illegal  = i_alu_op == AOP_RTYPE && !w_known;
    o_alu_ctrl = i_alu_op == AOP_SUB ? ALU_SUB :
                 i_alu_op == AOP_OR ? ALU_OR :
                 i_alu_op == AOP_RTYPE ? w_rtype : ALU_ADD;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with stall/flush bubbles, registered ALU decode
// and combinational operand forwarding on the EX side.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);
  ex_state_t   r_ex;
  ex_state_t   w_next;
  logic [3:0]  w_alu_ctrl;
  logic        w_illegal;
  logic [31:0] w_imm_ext;
  logic [31:0] w_rt_fwd;
  alu_ctrl_dec u_dec (
    .i_alu_op  (bus.id_alu_op),
    .i_funct   (bus.id_funct),
    .o_alu_ctrl(w_alu_ctrl),
    .o_illegal (w_illegal)
  );
  // ORI-class immediates are logical, so they zero-extend.
  assign w_imm_ext = bus.id_alu_op == AOP_OR ? {16'd0, bus.id_imm} : {{16{bus.id_imm[15]}}, bus.id_imm};
  always_comb begin
    w_next = r_ex;
    if (bus.flush || (!bus.stall && !bus.id_valid)) w_next = EX_BUBBLE;
    else if (!bus.stall)
      w_next = '{rs: bus.id_rs_data, rt: bus.id_rt_data, imm: w_imm_ext,
                 dest: bus.id_reg_dst ? bus.id_rd : bus.id_rt, alu_ctrl: w_alu_ctrl,
                 alu_src: bus.id_alu_src, reg_write: bus.id_reg_write && !w_illegal,
                 mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
                 mem_to_reg: bus.id_mem_to_reg, valid: 1'b1, illegal: w_illegal};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex <= EX_BUBBLE;
    else r_ex <= w_next;
  end
  assign w_rt_fwd          = fwd_mux(bus.fwd_b_sel, r_ex.rt, bus.exmem_result, bus.memwb_result);
  assign bus.input1        = fwd_mux(bus.fwd_a_sel, r_ex.rs, bus.exmem_result, bus.memwb_result);
  assign bus.input2        = r_ex.alu_src ? r_ex.imm : w_rt_fwd;
  assign bus.ex_store_data = w_rt_fwd;
  assign bus.ALUCtrl       = r_ex.alu_ctrl;
  assign bus.ex_dest       = r_ex.dest;
  assign bus.ex_reg_write  = r_ex.reg_write;
  assign bus.ex_mem_read   = r_ex.mem_read;
  assign bus.ex_mem_write  = r_ex.mem_write;
  assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_illegal    = r_ex.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register: reset, decode, extension,
// forwarding, stall, flush, bubbles and asynchronous reset.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic valid, input logic [1:0] op, input logic [5:0] funct,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input logic [4:0] rt_idx, input logic [4:0] rd, input logic alu_src,
                        input logic reg_dst, input logic rw, input logic mr, input logic mw,
                        input logic m2r);
    bus.id_valid = valid;
    bus.id_alu_op = op;
    bus.id_funct = funct;
    bus.id_rs_data = rs;
    bus.id_rt_data = rt;
    bus.id_imm = imm;
    bus.id_rt = rt_idx;
    bus.id_rd = rd;
    bus.id_alu_src = alu_src;
    bus.id_reg_dst = reg_dst;
    bus.id_reg_write = rw;
    bus.id_mem_read = mr;
    bus.id_mem_write = mw;
    bus.id_mem_to_reg = m2r;
  endtask
  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, ".alu"}, 32'(bus.ALUCtrl), 32'h2);
    chk({tag, ".dest"}, 32'(bus.ex_dest), 32'd0);
    chk({tag, ".rw"}, 32'(bus.ex_reg_write), 32'd0);
    chk({tag, ".ill"}, 32'(bus.ex_illegal), 32'd0);
    chk({tag, ".in1"}, bus.input1, 32'd0);
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.fwd_a_sel = 2'b00;
    bus.fwd_b_sel = 2'b00;
    bus.exmem_result = 32'd0;
    bus.memwb_result = 32'd0;
    set_id(1, 2'b10, 6'b100000, 32'h55, 32'h66, 16'h1234, 5'd1, 5'd2, 0, 1, 1, 1, 1, 1);
    tick();
    chk_bubble("reset");
    chk("reset.mr", 32'(bus.ex_mem_read), 32'd0);
    chk("reset.mw", 32'(bus.ex_mem_write), 32'd0);
    chk("reset.m2r", 32'(bus.ex_mem_to_reg), 32'd0);
    rst_n = 1'b1;
    set_id(1, 2'b10, 6'b100010, 32'd128, 32'd128, 16'h0, 5'd3, 5'd5, 0, 1, 1, 0, 0, 0);
    tick();
    chk("sub.in1", bus.input1, 32'd128);
    chk("sub.in2", bus.input2, 32'd128);
    chk("sub.alu", 32'(bus.ALUCtrl), 32'h6);
    chk("sub.dest", 32'(bus.ex_dest), 32'd5);
    chk("sub.rw", 32'(bus.ex_reg_write), 32'd1);
    chk("sub.valid", 32'(bus.ex_valid), 32'd1);
    set_id(1, 2'b00, 6'b0, 32'd100, 32'd3, 16'hFFFC, 5'd8, 5'd5, 1, 0, 1, 1, 0, 1);
    tick();
    chk("lw.in1", bus.input1, 32'd100);
    chk("lw.in2", bus.input2, 32'hFFFFFFFC);
    chk("lw.alu", 32'(bus.ALUCtrl), 32'h2);
    chk("lw.dest", 32'(bus.ex_dest), 32'd8);
    chk("lw.mr", 32'(bus.ex_mem_read), 32'd1);
    chk("lw.m2r", 32'(bus.ex_mem_to_reg), 32'd1);
    bus.id_alu_op = 2'b11;
    tick();
    chk("ori.in2", bus.input2, 32'h0000FFFC);
    chk("ori.alu", 32'(bus.ALUCtrl), 32'h1);
    set_id(1, 2'b00, 6'b0, 32'd1, 32'd2, 16'h0010, 5'd4, 5'd0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("sw.in1", bus.input1, 32'd1);
    chk("sw.in2", bus.input2, 32'd2);
    chk("sw.st", bus.ex_store_data, 32'd2);
    chk("sw.mw", 32'(bus.ex_mem_write), 32'd1);
    chk("sw.rw", 32'(bus.ex_reg_write), 32'd0);
    bus.fwd_a_sel = 2'b01;
    bus.exmem_result = 32'd7;
    bus.fwd_b_sel = 2'b10;
    bus.memwb_result = 32'd9;
    #1;
    chk("fwd.in1", bus.input1, 32'd7);
    chk("fwd.in2", bus.input2, 32'd9);
    chk("fwd.st", bus.ex_store_data, 32'd9);
    bus.fwd_a_sel = 2'b10;
    bus.fwd_b_sel = 2'b01;
    #1;
    chk("fwdx.in1", bus.input1, 32'd9);
    chk("fwdx.in2", bus.input2, 32'd7);
    bus.fwd_a_sel = 2'b11;
    bus.fwd_b_sel = 2'b11;
    #1;
    chk("fwd11.in1", bus.input1, 32'd1);
    chk("fwd11.in2", bus.input2, 32'd2);
    bus.fwd_a_sel = 2'b00;
    bus.fwd_b_sel = 2'b00;
    set_id(1, 2'b10, 6'b100100, 32'd5, 32'd6, 16'h0, 5'd1, 5'd9, 0, 1, 1, 0, 0, 0);
    tick();
    chk("and.alu", 32'(bus.ALUCtrl), 32'h0);
    chk("and.dest", 32'(bus.ex_dest), 32'd9);
    bus.stall = 1'b1;
    set_id(1, 2'b10, 6'b101010, 32'd77, 32'd78, 16'h0, 5'd1, 5'd12, 0, 1, 1, 0, 0, 0);
    tick();
    chk("stall1.alu", 32'(bus.ALUCtrl), 32'h0);
    chk("stall1.dest", 32'(bus.ex_dest), 32'd9);
    chk("stall1.in1", bus.input1, 32'd5);
    set_id(0, 2'b01, 6'b0, 32'd88, 32'd89, 16'h0, 5'd2, 5'd13, 0, 1, 0, 0, 0, 0);
    tick();
    chk("stall2.alu", 32'(bus.ALUCtrl), 32'h0);
    chk("stall2.in2", bus.input2, 32'd6);
    chk("stall2.valid", 32'(bus.ex_valid), 32'd1);
    bus.fwd_a_sel = 2'b01;
    bus.exmem_result = 32'd33;
    #1;
    chk("stallfwd.in1", bus.input1, 32'd33);
    bus.fwd_a_sel = 2'b00;
    bus.flush = 1'b1;
    tick();
    chk_bubble("stflush");
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_id(1, 2'b10, 6'b101010, 32'd77, 32'd78, 16'h0, 5'd1, 5'd12, 0, 1, 1, 0, 0, 0);
    tick();
    chk("slt.alu", 32'(bus.ALUCtrl), 32'h7);
    chk("slt.dest", 32'(bus.ex_dest), 32'd12);
    bus.id_funct = 6'b100101;
    tick();
    chk("or.alu", 32'(bus.ALUCtrl), 32'h1);
    bus.id_funct = 6'b100000;
    tick();
    chk("add.alu", 32'(bus.ALUCtrl), 32'h2);
    bus.id_funct = 6'b000000;
    tick();
    chk("ill.ill", 32'(bus.ex_illegal), 32'd1);
    chk("ill.rw", 32'(bus.ex_reg_write), 32'd0);
    chk("ill.alu", 32'(bus.ALUCtrl), 32'h2);
    chk("ill.valid", 32'(bus.ex_valid), 32'd1);
    bus.id_valid = 1'b0;
    tick();
    chk_bubble("novalid");
    set_id(1, 2'b10, 6'b101010, 32'd44, 32'd45, 16'h0, 5'd1, 5'd14, 0, 1, 1, 0, 0, 0);
    tick();
    chk("pre_flush.valid", 32'(bus.ex_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    chk_bubble("flush");
    bus.flush = 1'b0;
    set_id(1, 2'b10, 6'b100010, 32'd21, 32'd22, 16'h0, 5'd3, 5'd5, 0, 1, 1, 0, 0, 0);
    tick();
    chk("pre_rst.alu", 32'(bus.ALUCtrl), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bubble("async_rst");
    tick();
    chk("rst_hold.valid", 32'(bus.ex_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.valid", 32'(bus.ex_valid), 32'd1);
    chk("post_rst.alu", 32'(bus.ALUCtrl), 32'h6);
    chk("post_rst.in1", bus.input1, 32'd21);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: stall  input  1  hold all EX-stage registers this cycle.
REQ-004 SHALL: flush  input  1  load a bubble into the EX stage this cycle.
REQ-005 SHALL: id_valid  input  1  ID slot holds a real instruction.
REQ-006 SHALL: id_rs_data, id_rt_data  input  32 each  register-file read data.
REQ-007 SHALL: id_imm  input  16  instruction immediate; id_rt, id_rd  input  5 each.
REQ-008 SHALL: id_alu_op  input  2  main-decoder ALU class; id_funct  input  6  R-type funct.
REQ-009 SHALL: id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  control bits.
REQ-010 SHALL: fwd_a_sel, fwd_b_sel  input  2 each  00 register, 01 exmem_result, 10 memwb_result, 11 register.
REQ-011 SHALL: exmem_result, memwb_result  input  32 each  forwarding sources.
REQ-012 SHALL: input1, input2  output  32 each  ALU operands; ALUCtrl  output  4  ALU operation.
REQ-013 SHALL: ex_store_data  output  32  forwarded rt value for stores.
REQ-014 SHALL: ex_dest  output  5; ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid, ex_illegal  output  1 each.

Function
REQ-015 SHALL: ALUCtrl decode in ID, registered: alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0001 (or).
REQ-016 SHALL: alu_op 10 by funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111.
REQ-017 SHALL: alu_op 10 with any other funct registers ALUCtrl 0010, ex_illegal 1, ex_reg_write 0.
REQ-018 SHALL: immediate zero-extended when id_alu_op=11, else sign-extended to 32 bits, registered.
REQ-019 SHALL: ex_dest registered as id_rd when id_reg_dst=1, else id_rt.
REQ-020 SHALL: latency exactly one cycle from ID inputs to registered EX state when stall=0, flush=0.
REQ-021 SHALL: forwarding muxes combinational after the registers, using same-cycle fwd_*_sel and results.
REQ-022 SHALL: input1 = forwarded rs; ex_store_data = forwarded rt; input2 = ex_imm_ext if alu_src_q else forwarded rt.
REQ-023 SHALL: stall=1, flush=0: every register holds; outputs change only via forwarding inputs.
REQ-024 SHALL: flush=1 (regardless of stall): bubble loaded -- all controls 0, ex_valid 0, ex_illegal 0, ALUCtrl 0010, data/imm/dest 0.
REQ-025 SHALL: id_valid=0 with no stall/flush loads a bubble identical to REQ-024.
REQ-026 SHALL: rst_n low mid-operation forces bubble state immediately; first capture on first rising edge after release.

Reset
REQ-027 SHALL: reset value of all registered outputs equals the bubble of REQ-024 (input1/input2 then reflect fwd selection of zeroed registers or results).
REQ-028 SHALL: no register without asynchronous reset; no output depends on uninitialised state.

Structure
REQ-029 SHALL: shared package holds ALUCtrl codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111), alu_op classes, funct codes, fwd select codes.
REQ-030 SHALL: one sub-module alu_ctrl_dec (combinational alu_op+funct -> ALUCtrl, illegal); registers and forwarding muxes in id_ex_stage.
REQ-031 SHALL: ALUCtrl encoding identical to the existing ALU module's decode; outputs connect to it by name.

Verification
REQ-032 SHALL: reset; rst_n=0 -> ALUCtrl=0010, ex_valid=0, all controls 0, ex_dest=0.
REQ-033 SHALL: R-type rs=128, rt=128, alu_op 10, funct 100010, reg_dst 1, rd 5 -> next cycle input1=128, input2=128, ALUCtrl=0110, ex_dest=5, ex_reg_write=1.
REQ-034 SHALL: alu_op 00, imm 16'hFFFC, alu_src 1 -> input2=32'hFFFFFFFC; alu_op 11, same imm -> input2=32'h0000FFFC, ALUCtrl=0001.
REQ-035 SHALL: fwd_a_sel 01, exmem_result=7; fwd_b_sel 10, memwb_result=9, alu_src 0 -> input1=7, input2=9, ex_store_data=9 same cycle.
REQ-036 SHALL: stall 2 cycles while ID changes -> EX outputs unchanged; stall+flush together -> bubble next cycle.
REQ-037 SHALL: alu_op 10, funct 000000 -> ex_illegal=1, ex_reg_write=0, ALUCtrl=0010.
